fir_sequencer: RTL and testbench



---
 rtl/fir_pkg.sv | 17 +
 rtl/fir_result_fifo.sv | 70 +++++++
 rtl/fir_sequencer.sv | 147 ++++++++++++++
 tb/tb_fir_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and FSM state type for the FIR sample sequencer.
package fir_pkg;

    localparam int DEF_NR_OF_TAPS      = 10;
    localparam int DEF_SAMPLE_WIDTH    = 8;
    localparam int DEF_OUT_WIDTH       = 8;
    localparam int DEF_FIFO_DEPTH      = 4;
    localparam int DEF_TIMEOUT_CYCLES  = 64;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_IDLE     = 2'd1,
        ST_ISSUE    = 2'd2,
        ST_WAIT_DAV = 2'd3
    } fir_state_e;

endpackage

// File: rtl/fir_result_fifo.sv
// Result buffer between the FIR and the downstream consumer; head entry is
// exposed combinationally, pushes become visible on the following cycle.
module fir_result_fifo
    import fir_pkg::*;
#(
    parameter int OutWidth  = DEF_OUT_WIDTH,
    parameter int FifoDepth = DEF_FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [OutWidth-1:0]            din,
    output logic [OutWidth-1:0]            dout,
    output logic [$clog2(FifoDepth):0]     count,
    output logic                           empty,
    output logic                           full
);

    localparam int AW = $clog2(FifoDepth);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FifoDepth);

    logic [OutWidth-1:0] mem_q [FifoDepth];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q, count_d;
    logic                do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign count   = count_q;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // At full a push is only taken when the same edge frees the head slot.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/fir_sequencer.sv
// Feeds samples one at a time into an attached FIR, waits for its result,
// and buffers results for a valid/ready consumer.
module fir_sequencer
    import fir_pkg::*;
#(
    parameter int NrOfTaps      = DEF_NR_OF_TAPS,
    parameter int SampleWidth   = DEF_SAMPLE_WIDTH,
    parameter int OutWidth      = DEF_OUT_WIDTH,
    parameter int FifoDepth     = DEF_FIFO_DEPTH,
    parameter int TimeoutCycles = DEF_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SampleWidth-1:0] in_sample,
    output logic                   fir_sampleClk,
    output logic [SampleWidth-1:0] fir_sample,
    input  logic                   fir_dav,
    input  logic [OutWidth-1:0]    fir_sum,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OutWidth-1:0]    out_sum,
    output logic                   busy,
    output logic                   timeout_err,
    output logic                   spurious_err,
    input  logic                   clr_err,
    output logic [1:0]             dbg_state
);

    // Handshakes: a transfer happens on any rising edge where valid and ready
    // are both 1; ready never depends on valid, and a data word is only
    // sampled on a transfer edge.

    localparam int IW  = $clog2(NrOfTaps + 1);
    localparam int TW  = $clog2(TimeoutCycles + 1);
    localparam int CW  = $clog2(FifoDepth) + 1;
    localparam int CW1 = CW + 1;
    localparam logic [IW-1:0]  INIT_LAST = IW'(NrOfTaps);
    localparam logic [IW-1:0]  INIT_ONE  = IW'(1);
    localparam logic [TW-1:0]  TMO_LOAD  = TW'(TimeoutCycles);
    localparam logic [TW-1:0]  TMO_ONE   = TW'(1);
    localparam logic [CW1-1:0] DEPTH_W   = CW1'(FifoDepth);

    fir_state_e             state_q, state_d;
    logic [IW-1:0]          init_cnt_q, init_cnt_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [SampleWidth-1:0] sample_q, sample_d;
    logic                   tmo_err_q, tmo_err_d;
    logic                   spur_err_q, spur_err_d;
    logic                   set_tmo, set_spur;
    logic                   push, pop, fifo_empty, fifo_full, outstanding;
    logic [CW-1:0]          fifo_count;
    logic [CW1-1:0]         slots_used;

    // A sample in flight holds a FIFO slot so its result can always be stored.
    assign outstanding = (state_q == ST_ISSUE) || (state_q == ST_WAIT_DAV);
    assign slots_used  = {1'b0, fifo_count} + {{CW{1'b0}}, outstanding};
    assign in_ready    = (state_q == ST_IDLE) && !fifo_full && (slots_used < DEPTH_W);
    assign push        = (state_q == ST_WAIT_DAV) && fir_dav;
    assign pop         = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        tmo_d      = tmo_q;
        sample_d   = sample_q;
        set_tmo    = 1'b0;
        set_spur   = 1'b0;
        case (state_q)
            ST_INIT: begin
                set_spur = fir_dav;
                if (init_cnt_q == INIT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + INIT_ONE;
                end
            end
            ST_IDLE: begin
                set_spur = fir_dav;
                if (in_valid && in_ready) begin
                    sample_d = in_sample;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                set_spur = fir_dav;
                tmo_d    = TMO_LOAD;
                state_d  = ST_WAIT_DAV;
            end
            ST_WAIT_DAV: begin
                tmo_d = tmo_q - TMO_ONE;
                if (fir_dav) begin
                    state_d = ST_IDLE;
                end else if (tmo_q <= TMO_ONE) begin
                    set_tmo = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
        tmo_err_d  = (tmo_err_q && !clr_err) || set_tmo;
        spur_err_d = (spur_err_q && !clr_err) || set_spur;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            tmo_q      <= '0;
            sample_q   <= '0;
            tmo_err_q  <= 1'b0;
            spur_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            tmo_q      <= tmo_d;
            sample_q   <= sample_d;
            tmo_err_q  <= tmo_err_d;
            spur_err_q <= spur_err_d;
        end
    end

    fir_result_fifo #(
        .OutWidth  (OutWidth),
        .FifoDepth (FifoDepth)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (fir_sum),
        .dout  (out_sum),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign out_valid     = !fifo_empty;
    assign fir_sampleClk = (state_q == ST_ISSUE);
    assign fir_sample    = sample_q;
    assign busy          = (state_q != ST_IDLE);
    assign timeout_err   = tmo_err_q;
    assign spurious_err  = spur_err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed-plus-random bench for fir_sequencer with an FIR latency model and
// a queue model of the result buffer.
module tb_fir_sequencer;
    import fir_pkg::*;

    localparam int NR    = 10;
    localparam int SW    = 8;
    localparam int OW    = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SW-1:0] in_sample = '0;
    logic          fir_sampleClk;
    logic [SW-1:0] fir_sample;
    logic          fir_dav = 1'b0;
    logic [OW-1:0] fir_sum = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_sum;
    logic          busy, timeout_err, spurious_err;
    logic          clr_err = 1'b0;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    fir_sequencer #(
        .NrOfTaps      (NR),
        .SampleWidth   (SW),
        .OutWidth      (OW),
        .FifoDepth     (DEPTH),
        .TimeoutCycles (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sample     (in_sample),
        .fir_sampleClk (fir_sampleClk),
        .fir_sample    (fir_sample),
        .fir_dav       (fir_dav),
        .fir_sum       (fir_sum),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sum       (out_sum),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .spurious_err  (spurious_err),
        .clr_err       (clr_err),
        .dbg_state     (dbg_state)
    );

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] got_q[$];
    int            n_tests = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            fir_lat = 8;
    bit            pend_valid = 1'b0;
    int            pend_due = 0;
    logic [OW-1:0] pend_sum = '0;
    logic [SW-1:0] acc_sample = '0;
    bit            inj_dav = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: record this cycle's transfers, cross the edge, then check
    // outputs against the models and drive the FIR response for the new cycle.
    task automatic tick();
        bit xfer;
        xfer = 1'b0;
        if (reset) begin
            exp_q.delete();
            pend_valid = 1'b0;
        end else begin
            xfer = in_valid && in_ready;
            if (xfer) acc_sample = in_sample;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                got_q.push_back(out_sum);
                void'(exp_q.pop_front());
            end
            if (fir_dav && !inj_dav) exp_q.push_back(fir_sum);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        inj_dav = 1'b0;
        chk("sample_clk", fir_sampleClk, xfer);
        if (fir_sampleClk && xfer) begin
            chk("fir_sample", fir_sample, acc_sample);
            if (fir_lat > 0) begin
                pend_valid = 1'b1;
                pend_due   = cyc + fir_lat;
                pend_sum   = acc_sample;
            end
        end
        chk("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) chk("out_sum", out_sum, exp_q[0]);
        fir_dav = pend_valid && (pend_due == cyc);
        fir_sum = fir_dav ? pend_sum : OW'($urandom);
        if (fir_dav) pend_valid = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [SW-1:0] s, input int budget, output bit ok);
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_sample = s;
        while (in_ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        ok = (in_ready === 1'b1);
        if (ok) tick();
        in_valid  = 1'b0;
        in_sample = SW'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit            ok;
        int            zeros;
        int            n;
        logic [SW-1:0] s [5];
        logic [SW-1:0] dir [3];

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        chk("rst_busy", busy, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_sample_clk", fir_sampleClk, 0);
        chk("rst_fir_sample", fir_sample, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_spurious_err", spurious_err, 0);
        chk("rst_state", dbg_state, 32'(ST_INIT));
        reset = 1'b0;

        // INIT length with in_valid held high, then three directed samples
        out_ready = 1'b1;
        fir_lat   = 8;
        in_valid  = 1'b1;
        in_sample = 8'h10;
        zeros = 0;
        while (in_ready !== 1'b1 && zeros < 50) begin
            zeros++;
            tick();
        end
        chk("init_ready_low", zeros, NR + 1);
        dir[0] = 8'h10; dir[1] = 8'h7F; dir[2] = 8'h80;
        got_q.delete();
        send(dir[0], 50, ok);
        chk("accept_0x10", ok, 1);
        chk("first_sample_clk", fir_sampleClk, 1);
        send(dir[1], 50, ok);
        chk("accept_0x7f", ok, 1);
        send(dir[2], 50, ok);
        chk("accept_0x80", ok, 1);
        tick_n(15);
        chk("dir_count", got_q.size(), 3);
        for (int i = 0; i < 3; i++) chk("dir_order", got_q[i], dir[i]);

        // Backpressure: four results fill the buffer, the fifth waits for a pop
        got_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) s[i] = SW'($urandom);
        for (int i = 0; i < 4; i++) begin
            fir_lat = $urandom_range(1, 20);
            send(s[i], 60, ok);
            chk("bp_accept", ok, 1);
        end
        tick_n(25);
        send(s[4], 40, ok);
        chk("bp_fifth_blocked", ok, 0);
        chk("bp_ready_low", in_ready, 0);
        in_valid  = 1'b1;
        in_sample = s[4];
        out_ready = 1'b1;
        chk("bp_ready_before_pop", in_ready, 0);
        tick();
        chk("bp_ready_after_pop", in_ready, 1);
        fir_lat = $urandom_range(1, 20);
        tick();
        in_valid = 1'b0;
        tick_n(30);
        chk("bp_count", got_q.size(), 5);
        for (int i = 0; i < 5; i++) chk("bp_order", got_q[i], s[i]);

        // FIR never answers: WAIT_DAV lasts exactly TMO clocks
        got_q.delete();
        fir_lat = 0;
        send(SW'($urandom), 20, ok);
        chk("tmo_accept", ok, 1);
        n = 0;
        while (timeout_err !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("tmo_latency", n, TMO + 1);
        chk("tmo_state_idle", dbg_state, 32'(ST_IDLE));
        chk("tmo_not_busy", busy, 0);
        chk("tmo_fifo_empty", out_valid, 0);
        chk("tmo_no_spur", spurious_err, 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("tmo_cleared", timeout_err, 0);

        // Latest legal answer, TMO clocks after issue, is still accepted
        fir_lat = TMO;
        s[0] = SW'($urandom);
        send(s[0], 20, ok);
        tick_n(TMO + 5);
        chk("tmo_edge_no_err", timeout_err, 0);
        chk("tmo_edge_count", got_q.size(), 1);
        if (got_q.size() == 1) chk("tmo_edge_value", got_q[0], s[0]);

        // Spurious dav in IDLE with one result buffered
        got_q.delete();
        out_ready = 1'b0;
        fir_lat = 3;
        s[0] = SW'($urandom);
        send(s[0], 20, ok);
        tick_n(8);
        inj_dav = 1'b1;
        fir_dav = 1'b1;
        fir_sum = ~s[0];
        tick();
        chk("spur_set", spurious_err, 1);
        out_ready = 1'b1;
        tick_n(3);
        chk("spur_discarded", got_q.size(), 1);
        clr_err = 1'b1;
        inj_dav = 1'b1;
        fir_dav = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_vs_event", spurious_err, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("spur_cleared", spurious_err, 0);

        // Reset in WAIT_DAV with two results buffered
        out_ready = 1'b0;
        fir_lat = 5;
        send(SW'($urandom), 20, ok);
        send(SW'($urandom), 20, ok);
        tick_n(10);
        fir_lat = 30;
        send(SW'($urandom), 20, ok);
        tick_n(5);
        chk("mid_state_wait", dbg_state, 32'(ST_WAIT_DAV));
        chk("mid_buffered", out_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_busy", busy, 1);
        in_valid  = 1'b1;
        in_sample = SW'($urandom);
        zeros = 0;
        while (in_ready !== 1'b1 && zeros < 50) begin
            if (zeros == 3) begin
                inj_dav = 1'b1;
                fir_dav = 1'b1;
                fir_sum = OW'($urandom);
            end
            zeros++;
            tick();
        end
        in_valid = 1'b0;
        chk("mid_init_len", zeros, NR + 1);
        chk("mid_spur_init", spurious_err, 1);
        out_ready = 1'b1;
        tick_n(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
